// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - op encodings and state type for the iterative divider
package div_pkg;

    // op_in encoding: bit0 = unsigned, bit1 = remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam int OP_UNSIGNED_BIT = 0;
    localparam int OP_REM_BIT      = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIVIDING = 2'd1,
        FIXUP    = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract division step
//
// Ports:
//   rem_in      partial remainder before the step
//   quo_in      quotient/dividend shift register; its MSB is shifted into rem
//   divisor_in  divisor magnitude
//   rem_out     partial remainder after the step
//   quo_out     shift register with the new quotient bit in the LSB
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // The shifted remainder can reach WIDTH+1 bits, so compare at that width.
    // When ge holds the difference is below the divisor and fits in WIDTH bits.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, divisor_in});
    assign diff    = shifted[WIDTH-1:0] - divisor_in;
    assign rem_out = ge ? diff : shifted[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ge};

endmodule

// File: rtl/riscv_divider.sv
// rtl/riscv_divider.sv - iterative RISC-V DIV/DIVU/REM/REMU unit
//
// Ports:
//   clk_in          clock, rising edge
//   rst_in          synchronous active-high reset
//   dividend_in     dividend operand
//   divisor_in      divisor operand
//   op_in           00 DIV, 01 DIVU, 10 REM, 11 REMU
//   data_valid_in   request strobe, ignored while busy_out
//   kill_in         flush; abandons any operation in flight
//   result_out      quotient or remainder, held until the next completion
//   data_valid_out  one-cycle completion pulse
//   error_out       divide-by-zero flag, qualified by data_valid_out
//   busy_out        operation in flight
module riscv_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    input  logic [1:0]       op_in,
    input  logic             data_valid_in,
    input  logic             kill_in,
    output logic [WIDTH-1:0] result_out,
    output logic             data_valid_out,
    output logic             error_out,
    output logic             busy_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dsr_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             rem_sel_r;
    logic             fast_err_r;

    logic             is_signed;
    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] fast_val;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    assign is_signed = ~op_in[OP_UNSIGNED_BIT];
    assign dvd_neg   = is_signed & dividend_in[WIDTH-1];
    assign dsr_neg   = is_signed & divisor_in[WIDTH-1];
    assign dvd_mag   = dvd_neg ? (~dividend_in + 1'b1) : dividend_in;
    assign dsr_mag   = dsr_neg ? (~divisor_in + 1'b1) : divisor_in;
    assign div_zero  = (divisor_in == '0);
    assign overflow  = is_signed & (dividend_in == MOST_NEG) & (divisor_in == '1);

    // Results of the two special cases that bypass the iteration.
    always_comb begin
        fast_val = '0;
        if (div_zero)
            fast_val = op_in[OP_REM_BIT] ? dividend_in : '1;
        else
            fast_val = op_in[OP_REM_BIT] ? '0 : dividend_in;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in     (rem_r),
        .quo_in     (quo_r),
        .divisor_in (dsr_r),
        .rem_out    (step_rem),
        .quo_out    (step_quo)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            cnt            <= '0;
            rem_r          <= '0;
            quo_r          <= '0;
            dsr_r          <= '0;
            q_neg_r        <= 1'b0;
            r_neg_r        <= 1'b0;
            rem_sel_r      <= 1'b0;
            fast_err_r     <= 1'b0;
            result_out     <= '0;
            data_valid_out <= 1'b0;
            error_out      <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (kill_in) begin
                state    <= IDLE;
                busy_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (busy_out) begin
                            // Fast-path result was staged in quo_r on the accept edge.
                            result_out     <= quo_r;
                            error_out      <= fast_err_r;
                            data_valid_out <= 1'b1;
                            busy_out       <= 1'b0;
                        end else if (data_valid_in) begin
                            busy_out  <= 1'b1;
                            rem_sel_r <= op_in[OP_REM_BIT];
                            if (div_zero || overflow) begin
                                quo_r      <= fast_val;
                                fast_err_r <= div_zero;
                            end else begin
                                state      <= DIVIDING;
                                quo_r      <= dvd_mag;
                                dsr_r      <= dsr_mag;
                                rem_r      <= '0;
                                cnt        <= CW'(WIDTH);
                                q_neg_r    <= dvd_neg ^ dsr_neg;
                                r_neg_r    <= dvd_neg;
                                fast_err_r <= 1'b0;
                            end
                        end
                    end
                    DIVIDING: begin
                        rem_r <= step_rem;
                        quo_r <= step_quo;
                        cnt   <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            state <= FIXUP;
                    end
                    FIXUP: begin
                        if (rem_sel_r)
                            result_out <= r_neg_r ? (~rem_r + 1'b1) : rem_r;
                        else
                            result_out <= q_neg_r ? (~quo_r + 1'b1) : quo_r;
                        error_out      <= 1'b0;
                        data_valid_out <= 1'b1;
                        busy_out       <= 1'b0;
                        state          <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_divider.sv
// tb/tb_riscv_divider.sv - self-checking bench for riscv_divider
module tb_riscv_divider;
    import div_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [1:0]   op;
    logic         dv_in;
    logic         kill;
    logic [W-1:0] result;
    logic         dv_out;
    logic         err;
    logic         busy;

    riscv_divider #(.WIDTH(W)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .dividend_in    (dividend),
        .divisor_in     (divisor),
        .op_in          (op),
        .data_valid_in  (dv_in),
        .kill_in        (kill),
        .result_out     (result),
        .data_valid_out (dv_out),
        .error_out      (err),
        .busy_out       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           due;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         err;
    } vec_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] last_res = '0;
    logic         last_err = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        if (b == '0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Behavioural reference for randomised operands.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sd;
        sa = a;
        sd = b;
        e  = 1'b0;
        if (b == '0) begin
            e = 1'b1;
            r = o[1] ? a : '1;
        end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = o[1] ? '0 : a;
        end else if (o[0]) begin
            r = o[1] ? (a % b) : (a / b);
        end else begin
            r = o[1] ? W'(sa % sd) : W'(sa / sd);
        end
    endfunction

    // Completion monitor: every data_valid_out must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && dv_out) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got result 0x%0h with no request outstanding (cycle %0d)", result, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("error", err, e.err);
                check("latency", cyc, e.due);
                last_res = e.res;
                last_err = e.err;
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] r, input logic e);
        exp_t x;
        @(negedge clk);
        op       = o;
        dividend = a;
        divisor  = b;
        dv_in    = 1'b1;
        @(posedge clk);
        #1;
        dv_in = 1'b0;
        if (push) begin
            x.res = r;
            x.err = e;
            x.due = cyc + latency(o, a, b);
            sb.push_back(x);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d results outstanding expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        check("hold_result", result, last_res);
        check("hold_error", err, last_err);
        check("idle_busy", busy, 1'b0);
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
        vecs[4]  = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
        vecs[5]  = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
        vecs[6]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
        vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          32'd5,          1'b1};
        vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
        vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[10] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[11] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
        vecs[12] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[13] = '{OP_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0};
        vecs[14] = '{OP_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0};
        vecs[15] = '{OP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0};
        vecs[16] = '{OP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0};
        vecs[17] = '{OP_DIVU, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b1};

        rst = 1'b1; dividend = '0; divisor = '0; op = '0; dv_in = 1'b0; kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, '0);
        check("reset_valid", dv_out, 1'b0);
        check("reset_error", err, 1'b0);
        check("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors, one at a time.
        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].res, vecs[i].err);
            drain();
        end

        // Randomised operands against the behavioural model.
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   o;
            logic [W-1:0] a, b, r;
            logic         e;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            model(o, a, b, r, e);
            issue(o, a, b, 1'b1, r, e);
            drain();
        end

        // A request accepted in the same cycle as a fast-path completion.
        issue(OP_DIV, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        drain();

        // Second request while busy is ignored.
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        repeat (4) @(posedge clk);
        issue(OP_DIVU, 32'd9, 32'd3, 1'b0, '0, 1'b0);
        check("busy_during_op", busy, 1'b1);
        drain();
        repeat (5) @(posedge clk);

        // Kill at E0+10 abandons the operation.
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, '0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", busy, 1'b0);
        check("kill_result_held", result, last_res);
        repeat (40) @(posedge clk);
        issue(OP_DIVU, 32'd9, 32'd3, 1'b1, 32'd3, 1'b0);
        drain();

        // Kill in the cycle before the scheduled completion.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, '0, 1'b0);
        repeat (31) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("late_kill_busy", busy, 1'b0);
        check("late_kill_valid", dv_out, 1'b0);
        repeat (5) @(posedge clk);

        // Kill together with a request drops the request.
        @(negedge clk);
        op = OP_DIVU; dividend = 32'd50; divisor = 32'd5; dv_in = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        dv_in = 1'b0; kill = 1'b0;
        check("kill_req_busy", busy, 1'b0);
        repeat (40) @(posedge clk);

        // Reset at E0+20 abandons the operation and clears the outputs.
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, '0, 1'b0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_result", result, '0);
        check("rst_mid_error", err, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_valid", dv_out, 1'b0);
        last_res = '0;
        last_err = 1'b0;
        repeat (40) @(posedge clk);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion of the test sequence expected finish before 500000 ns");
        $fatal(1);
    end

endmodule

// File: doc/riscv_divider.md
RISCV_DIVIDER -- requirements
Module: riscv_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk_in  input  1  single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port dividend_in  input  WIDTH  dividend operand.
REQ-005 The block SHALL have port divisor_in  input  WIDTH  divisor operand.
REQ-006 The block SHALL have port op_in  input  2  operation select: bit0=1 unsigned, bit1=1 remainder (00 DIV, 01 DIVU, 10 REM, 11 REMU).
REQ-007 The block SHALL have port data_valid_in  input  1  request strobe, sampled with the operands and op_in.
REQ-008 The block SHALL have port kill_in  input  1  pipeline flush; abandons any operation in flight.
REQ-009 The block SHALL have port result_out  output  WIDTH  quotient or remainder, as selected by the captured op.
REQ-010 The block SHALL have port data_valid_out  output  1  one-cycle pulse marking result_out valid.
REQ-011 The block SHALL have port error_out  output  1  divide-by-zero flag, qualified by data_valid_out.
REQ-012 The block SHALL have port busy_out  output  1  high while an operation is in flight; requests are ignored while it is high.

Function
REQ-013 The block SHALL use states IDLE, DIVIDING and FIXUP.
REQ-014 In IDLE, data_valid_in=1 with kill_in=0 SHALL capture the operands and op_in and set busy_out=1 on the same edge (edge E0).
REQ-015 A request with divisor=0 SHALL take the fast path: IDLE->IDLE; result_out, data_valid_out=1 and error_out=1 after E0+1.
REQ-016 Divide-by-zero results SHALL be: quotient all-ones (both DIV and DIVU); remainder = dividend unmodified.
REQ-017 A signed request (DIV/REM) with dividend=most-negative and divisor=all-ones SHALL take the fast path with error_out=0.
REQ-018 Signed-overflow results SHALL be: quotient = dividend; remainder = 0.
REQ-019 Any other request SHALL transition IDLE->DIVIDING.
REQ-020 On entering DIVIDING, signed ops SHALL convert both operands to magnitudes and record the quotient sign (XOR of operand signs) and the remainder sign (dividend sign).
REQ-021 DIVIDING SHALL perform one restoring shift-subtract step per cycle, MSB first, on a WIDTH-bit partial remainder, with a compare one bit wider so no carry is lost, for exactly WIDTH cycles.
REQ-022 After the last step, the block SHALL enter FIXUP for one cycle, which negates the quotient and/or remainder per the recorded signs and selects the result by op bit1.
REQ-023 The FIXUP->IDLE edge SHALL be E0+WIDTH+1; on that edge result_out is written, data_valid_out=1, error_out=0 and busy_out=0.
REQ-024 Signed results SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-025 data_valid_out SHALL be high for exactly one cycle per completed request.
REQ-026 result_out and error_out SHALL hold their values until the next completion.
REQ-027 data_valid_in while busy_out=1 SHALL be ignored, with no queueing.
REQ-028 A new request SHALL be accepted in the same cycle data_valid_out is high, since the state is then IDLE.
REQ-029 kill_in=1 in any state SHALL, at the next edge, set state=IDLE and busy_out=0, suppress data_valid_out, and leave result_out unchanged.
REQ-030 kill_in and data_valid_in high together SHALL drop the request (kill wins).
REQ-031 kill_in in the cycle before a scheduled completion SHALL suppress that completion.

Reset
REQ-032 On rst_in=1 at a clock edge, the block SHALL set state=IDLE, busy_out=0, data_valid_out=0, error_out=0, result_out=0, and clear all internal registers (iteration counter, partial remainder, quotient, sign flags).
REQ-033 Reset mid-operation SHALL abandon the operation with no data_valid_out, and rst_in SHALL take priority over kill_in and data_valid_in.

Structure
REQ-034 Package div_pkg SHALL hold: the op_in encoding constants (OP_DIV, OP_DIVU, OP_REM, OP_REMU) and the state enum.
REQ-035 The iteration counter SHALL be $clog2(WIDTH)+1 bits, derived locally from WIDTH.
REQ-036 One combinational sub-module div_step (partial remainder and quotient in, shifted and conditionally subtracted values out) SHALL be instantiated once.

Verification (WIDTH=32)
REQ-037 DIVU 100/7 -> result 14 with data_valid_out after E0+33; REMU 100/7 -> 2.
REQ-038 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-039 DIV 5/0 -> 0xFFFFFFFF with error_out=1 after E0+1; REMU 5/0 -> 5 with error_out=1.
REQ-040 DIV 0x80000000/0xFFFFFFFF -> 0x80000000, error_out=0, after E0+1; REM -> 0.
REQ-041 Request 100/7 followed by a second request 5 cycles after E0 -> second ignored, single result 14; then kill_in pulsed at E0+10 of a fresh request -> no data_valid_out, busy_out=0 next cycle, a following request 9/3 -> 3.
REQ-042 rst_in asserted at E0+20 -> all outputs 0 the next cycle, no data_valid_out; a subsequent request completes normally.
